// File: rtl/zbuffer_clear.sv
// Z-buffer initialisation engine: owns RAM port A, fills every cell with the
// far-plane value on request and otherwise forwards depth-test writes.
module zbuffer_clear #(
    parameter int                   WIDTH          = 320,
    parameter int                   HEIGHT         = 240,
    parameter int                   DEPTH_W        = 8,
    parameter int                   ADDR_W         = 20,
    parameter logic [DEPTH_W-1:0]   CLEAR_VAL      = 8'hFF,
    parameter bit                   CLEAR_ON_RESET = 1'b1
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    input  logic               up_we,
    input  logic [ADDR_W-1:0]  up_addr,
    input  logic [DEPTH_W-1:0] up_din,
    output logic               up_stall,
    output logic               mem_ena,
    output logic [3:0]         mem_wea,
    output logic [ADDR_W-1:0]  mem_addra,
    output logic [DEPTH_W-1:0] mem_dina
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int CNT_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_pending_q, init_pending_d;
    logic             clear_done_q, clear_done_d;

    // State register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            init_pending_q <= CLEAR_ON_RESET;
            clear_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            init_pending_q <= init_pending_d;
            clear_done_q   <= clear_done_d;
        end
    end

    // Next-state logic; a request seen while clearing is dropped, not queued.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        init_pending_d = init_pending_q;
        clear_done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_start || init_pending_q) begin
                    state_d        = ST_CLEAR;
                    cnt_d          = '0;
                    init_pending_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d      = ST_DONE;
                    clear_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (clear_start) begin
                    state_d        = ST_CLEAR;
                    cnt_d          = '0;
                    init_pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: the port mux depends only on state, so pass-through is same-cycle.
    always_comb begin
        clear_busy = (state_q == ST_CLEAR);
        up_stall   = clear_busy;
        clear_done = clear_done_q;
        mem_ena    = 1'b1;
        if (clear_busy) begin
            mem_wea   = 4'hF;
            mem_addra = ADDR_W'(cnt_q);
            mem_dina  = CLEAR_VAL;
        end else begin
            mem_wea   = {4{up_we}};
            mem_addra = up_addr;
            mem_dina  = up_din;
        end
    end

endmodule

// File: tb/tb_zbuffer_clear.sv
// Directed bench for zbuffer_clear: full-size auto clear plus reduced-size
// instances for pass-through, stall, back-to-back and mid-clear reset cases.
module tb_zbuffer_clear;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Full-size instance, auto clear after reset
    logic        f_rst_n, f_start, f_we;
    logic [19:0] f_addr;
    logic [7:0]  f_din;
    logic        f_busy, f_done, f_stall, f_ena;
    logic [3:0]  f_wea;
    logic [19:0] f_addra;
    logic [7:0]  f_dina;

    // Reduced 8x4 instances: a auto-clears on reset, b does not
    logic        a_rst_n, a_start, a_we;
    logic [19:0] a_addr;
    logic [7:0]  a_din;
    logic        a_busy, a_done, a_stall, a_ena;
    logic [3:0]  a_wea;
    logic [19:0] a_addra;
    logic [7:0]  a_dina;

    logic        b_rst_n, b_start, b_we;
    logic [19:0] b_addr;
    logic [7:0]  b_din;
    logic        b_busy, b_done, b_stall, b_ena;
    logic [3:0]  b_wea;
    logic [19:0] b_addra;
    logic [7:0]  b_dina;

    zbuffer_clear u_full (
        .s_axi_aclk(clk), .s_axi_aresetn(f_rst_n), .clear_start(f_start),
        .clear_busy(f_busy), .clear_done(f_done), .up_we(f_we), .up_addr(f_addr),
        .up_din(f_din), .up_stall(f_stall), .mem_ena(f_ena), .mem_wea(f_wea),
        .mem_addra(f_addra), .mem_dina(f_dina)
    );

    zbuffer_clear #(.WIDTH(8), .HEIGHT(4), .CLEAR_ON_RESET(1'b1)) u_a (
        .s_axi_aclk(clk), .s_axi_aresetn(a_rst_n), .clear_start(a_start),
        .clear_busy(a_busy), .clear_done(a_done), .up_we(a_we), .up_addr(a_addr),
        .up_din(a_din), .up_stall(a_stall), .mem_ena(a_ena), .mem_wea(a_wea),
        .mem_addra(a_addra), .mem_dina(a_dina)
    );

    zbuffer_clear #(.WIDTH(8), .HEIGHT(4), .CLEAR_ON_RESET(1'b0)) u_b (
        .s_axi_aclk(clk), .s_axi_aresetn(b_rst_n), .clear_start(b_start),
        .clear_busy(b_busy), .clear_done(b_done), .up_we(b_we), .up_addr(b_addr),
        .up_din(b_din), .up_stall(b_stall), .mem_ena(b_ena), .mem_wea(b_wea),
        .mem_addra(b_addra), .mem_dina(b_dina)
    );

    // RAM models for port A
    logic [7:0] ram_f [76800];
    logic [7:0] ram_a [32];
    logic [7:0] ram_b [32];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 76800; i++) ram_f[i] <= 8'h00;
            for (int i = 0; i < 32; i++) begin
                ram_a[i] <= 8'h00;
                ram_b[i] <= 8'h00;
            end
        end else begin
            if (f_ena && f_wea == 4'hF && f_addra < 20'd76800) ram_f[f_addra] <= f_dina;
            if (a_ena && a_wea == 4'hF && a_addra < 20'd32) ram_a[a_addra[4:0]] <= a_dina;
            if (b_ena && b_wea == 4'hF && b_addra < 20'd32) ram_b[b_addra[4:0]] <= b_dina;
        end
    end

    // Cycle monitors
    int f_seq_err  = 0;
    int f_exp      = 0;
    int f_busy_cnt = 0;
    int f_done_cnt = 0;
    int f_done_at  = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;

    always @(negedge clk) begin
        if (f_rst_n && f_busy) begin
            if (f_addra !== 20'(f_exp) || f_stall !== 1'b1 || f_wea !== 4'hF || f_dina !== 8'hFF)
                f_seq_err <= f_seq_err + 1;
            f_exp      <= f_exp + 1;
            f_busy_cnt <= f_busy_cnt + 1;
        end
        if (f_done) begin
            f_done_cnt <= f_done_cnt + 1;
            f_done_at  <= cyc;
            if (f_busy) f_seq_err <= f_seq_err + 1;
        end
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int rel_cyc;
    int bad;

    initial begin
        f_rst_n = 1'b0; a_rst_n = 1'b0; b_rst_n = 1'b0;
        f_start = 1'b0; a_start = 1'b0; b_start = 1'b0;
        f_we = 1'b0; a_we = 1'b0; b_we = 1'b0;
        f_addr = '0; a_addr = '0; b_addr = '0;
        f_din = '0; a_din = '0; b_din = '0;
        repeat (3) tick();

        // Reset state and pass-through during reset
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_stall", a_stall, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_ena", a_ena, 1'b1);
        chk("rst_f_busy", f_busy, 1'b0);
        a_we = 1'b1; a_addr = 20'd7; a_din = 8'h5A;
        #1;
        chk("rst_pass_wea", a_wea, 4'hF);
        chk("rst_pass_addr", a_addra, 20'd7);
        chk("rst_pass_din", a_dina, 8'h5A);

        // Release resets; auto clear begins on the next edge
        tick();
        a_we = 1'b0;
        f_rst_n = 1'b1; a_rst_n = 1'b1; b_rst_n = 1'b1;
        rel_cyc = cyc;
        #1;
        chk("rel_busy_before_edge", a_busy, 1'b0);
        tick();
        chk("auto_busy", a_busy, 1'b1);
        chk("auto_stall", a_stall, 1'b1);
        chk("auto_addr0", a_addra, 20'd0);
        chk("auto_din", a_dina, 8'hFF);
        chk("auto_f_busy", f_busy, 1'b1);
        chk("noauto_b_busy", b_busy, 1'b0);

        // Upstream write and clear_start during a clear are both dropped
        repeat (9) tick();
        a_we = 1'b1; a_addr = 20'd3; a_din = 8'h11; a_start = 1'b1;
        #1;
        chk("stall_addr", a_addra, 20'd9);
        chk("stall_flag", a_stall, 1'b1);
        chk("stall_din", a_dina, 8'hFF);
        tick();
        a_we = 1'b0; a_start = 1'b0;
        n = 0;
        while (!a_done && n < 100) begin tick(); n++; end
        chk("a_done_latency", n, 22);
        chk("a_done_busy_low", a_busy, 1'b0);
        tick();
        chk("a_idle_busy", a_busy, 1'b0);
        chk("a_done_single", a_done, 1'b0);
        repeat (3) tick();
        chk("a_no_restart", a_busy, 1'b0);
        chk("a_done_count", a_done_cnt, 1);
        chk("a_ram3_kept", ram_a[3], 8'hFF);
        bad = 0;
        for (int i = 0; i < 32; i++) if (ram_a[i] !== 8'hFF) bad++;
        chk("a_ram_all_ff", bad, 0);

        // Idle pass-through
        a_we = 1'b1; a_addr = 20'd5; a_din = 8'h3C;
        #1;
        chk("pass_wea", a_wea, 4'hF);
        chk("pass_addr", a_addra, 20'd5);
        chk("pass_din", a_dina, 8'h3C);
        chk("pass_stall", a_stall, 1'b0);
        tick();
        a_we = 1'b0;
        #1;
        chk("pass_ram", ram_a[5], 8'h3C);
        chk("pass_wea_off", a_wea, 4'h0);

        // Back-to-back clears on b
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        #1;
        chk("b_busy", b_busy, 1'b1);
        chk("b_addr0", b_addra, 20'd0);
        n = 0;
        while (!b_done && n < 100) begin tick(); n++; end
        chk("b_busy_cycles", n, 32);
        chk("b_done_busy", b_busy, 1'b0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        #1;
        chk("b2b_busy", b_busy, 1'b1);
        chk("b2b_addr0", b_addra, 20'd0);
        chk("b2b_done_low", b_done, 1'b0);
        tick();
        chk("b2b_addr1", b_addra, 20'd1);
        n = 0;
        while (!b_done && n < 100) begin tick(); n++; end
        chk("b2b_latency", n, 31);
        tick();
        chk("b_idle", b_busy, 1'b0);
        chk("b_done_count", b_done_cnt, 2);
        bad = 0;
        for (int i = 0; i < 32; i++) if (ram_b[i] !== 8'hFF) bad++;
        chk("b_ram_all_ff", bad, 0);

        // Reset in the middle of a clear on a
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (5) tick();
        chk("mid_addr5", a_addra, 20'd5);
        a_addr = 20'd9; a_din = 8'h42; a_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_stall", a_stall, 1'b0);
        chk("mid_rst_addr", a_addra, 20'd9);
        chk("mid_rst_done", a_done, 1'b0);
        repeat (2) tick();
        a_rst_n = 1'b1;
        #1;
        chk("mid_rel_busy", a_busy, 1'b0);
        tick();
        chk("mid_restart_busy", a_busy, 1'b1);
        chk("mid_restart_addr0", a_addra, 20'd0);
        n = 0;
        while (!a_done && n < 100) begin tick(); n++; end
        chk("mid_restart_len", n, 32);
        tick();
        chk("mid_done_count", a_done_cnt, 2);

        // Full-size auto clear completes
        n = 0;
        while (f_done_cnt == 0 && n < 80000) begin tick(); n++; end
        tick();
        chk("f_busy_cycles", f_busy_cnt, 76800);
        chk("f_seq_err", f_seq_err, 0);
        chk("f_done_count", f_done_cnt, 1);
        chk("f_done_cycle", f_done_at, rel_cyc + 76801);
        chk("f_idle", f_busy, 1'b0);
        bad = 0;
        for (int i = 0; i < 76800; i++) if (ram_f[i] !== 8'hFF) bad++;
        chk("f_ram_all_ff", bad, 0);

        f_we = 1'b1; f_addr = 20'd1000; f_din = 8'h3C;
        #1;
        chk("f_pass_wea", f_wea, 4'hF);
        chk("f_pass_addr", f_addra, 20'd1000);
        chk("f_pass_din", f_dina, 8'h3C);
        chk("f_pass_stall", f_stall, 1'b0);
        tick();
        f_we = 1'b0;
        #1;
        chk("f_pass_ram", ram_f[1000], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zbuffer_clear.md
# zbuffer_clear

Depth-buffer initialisation engine that owns the write port (port A) of the 320x240x8 z-buffer block RAM. On a clear request it writes the far-plane value 8'hFF to every pixel address, one per clock, so the next frame's depth tests start from "nothing drawn". When idle it forwards the depth-test unit's port-A writes to the RAM unchanged. While clearing it stalls the depth-test unit. It is the writer-side counterpart that gives the depth-test reader a valid buffer every frame.

## Interface

- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- DEPTH_W, 8, depth word width
- ADDR_W, 20, RAM address width
- CLEAR_VAL, 8'hFF, value written to every cell (maximum depth)
- CLEAR_ON_RESET, 1, when 1 a clear runs automatically after reset deassertion

- s_axi_aclk  in  1  sole clock; all state on rising edge
- s_axi_aresetn  in  1  reset; asynchronous assert, active-low
- clear_start  in  1  single-cycle clear request (frame boundary)
- clear_busy  out  1  high while the engine owns the RAM port
- clear_done  out  1  one-cycle pulse after the last cell is written
- up_we  in  1  depth-test unit write enable
- up_addr  in  ADDR_W  depth-test unit address (y*WIDTH+x)
- up_din  in  DEPTH_W  depth-test unit write data
- up_stall  out  1  depth-test unit must hold; its writes are not performed
- mem_ena  out  1  RAM port A enable
- mem_wea  out  4  RAM port A byte write enables
- mem_addra  out  ADDR_W  RAM port A address
- mem_dina  out  DEPTH_W  RAM port A write data

## Operation

- States: IDLE, CLEAR, DONE. Internal 17-bit cell counter cnt; LAST = WIDTH*HEIGHT-1 = 76799.
- init_pending flag: reset value CLEAR_ON_RESET; cleared when CLEAR is entered.
- IDLE: if clear_start or init_pending -> CLEAR with cnt=0; else stay.
- CLEAR: write CLEAR_VAL at cnt. If cnt==LAST -> DONE; else cnt+1.
- DONE: clear_done=1 for exactly this cycle. If clear_start -> CLEAR with cnt=0; else -> IDLE.
- clear_start while in CLEAR is ignored. No queuing and no restart.
- Port mux is combinational from state:
  - In CLEAR: mem_ena=1, mem_wea=4'hF, mem_addra=zero-extended cnt, mem_dina=CLEAR_VAL, clear_busy=1, up_stall=1. up_we is dropped, and upstream must re-present the write after up_stall falls.
  - In IDLE and DONE: mem_ena=1, mem_wea={4{up_we}}, mem_addra=up_addr, mem_dina=up_din, clear_busy=0, up_stall=0.
- Reset values of registered state: state=IDLE, cnt=0, clear_done=0. Resulting outputs during reset: clear_busy=0, up_stall=0, mem_ena=1, with the mux passing up_* through.
- Reset mid-clear: the clear is abandoned, cnt=0, and no clear_done is issued. With CLEAR_ON_RESET=1 a full clear restarts after deassertion. With CLEAR_ON_RESET=0 the RAM contents are partial and undefined until the next clear_start.

## Timing

- Request to first write: clear_start sampled high at edge N puts the engine in CLEAR from N. Address 0 is written in cycle N+1 (captured by RAM at edge N+1).
- A full clear occupies exactly 76800 cycles of clear_busy=1, one address per cycle, ascending, no gaps.
- clear_done is high in the cycle immediately after the LAST write, with clear_busy=0 in that cycle.
- Back-to-back: clear_start in the DONE cycle restarts with zero idle cycles. Minimum period between clears is 76801 cycles.
- Auto-clear: with CLEAR_ON_RESET=1, the first rising edge after s_axi_aresetn deasserts moves IDLE->CLEAR. clear_busy rises after that edge.
- up_stall equals clear_busy exactly, combinationally, in the same cycle.
- Pass-through adds no register stage: up_* reach mem_* in the same cycle.

## Test plan

- Reset with CLEAR_ON_RESET=1, no stimulus -> clear_busy high for 76800 cycles; addresses 0..76799 each written once with 8'hFF; single clear_done pulse; RAM read-back all 8'hFF.
- CLEAR_ON_RESET=0, pulse clear_start at cycle 10 -> first write addr 0 in cycle 11; last write addr 76799 in cycle 76810; clear_done in cycle 76811.
- Idle pass-through: up_we=1, up_addr=20'd1000, up_din=8'h3C -> same-cycle mem_wea=4'hF, mem_addra=1000, mem_dina=8'h3C; up_stall=0.
- up_we=1 during a clear -> up_stall=1 and RAM shows no write at up_addr. clear_start pulsed mid-clear -> exactly one clear_done, no restart.
- clear_start asserted in the DONE cycle -> clear_busy low for only that cycle; second clear starts at addr 0 on the next cycle.
- s_axi_aresetn pulsed low at cnt=5000 -> outputs return to reset values immediately; no clear_done; with CLEAR_ON_RESET=1 the clear restarts at addr 0.
